spi_dout_shifter: RTL and testbench

//  Serialises the byte stream from the read-memory stage onto the SPI IO pins in x1/x2/x4 mode, MSB first.

---
 rtl/spi_dout_shifter.sv | 208 ++++++++++++++++++++
 tb/tb_spi_dout_shifter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_dout_shifter.sv
// ---------------------------------------------------------------------------
// spi_dout_shifter
//
// Sends the read-stage byte stream out on the SPI IO pads, MSB first, in
// x1, x2 or x4 mode. After an optional run of dummy clocks it fetches one
// byte per byte-time using rd_req. It keeps shifting until stop (CS# high)
// or reset.
//
// Optional feature: define DOUT_BYTE_CNT_EN to add the byte_cnt output and
// the CNT_W parameter. In the default build both are absent.
//
// Parameters
//   DUMMY_W    width of dummy_cnt (0 .. 2^DUMMY_W-1 dummy clocks)
//   CNT_W      width of byte_cnt (only with DOUT_BYTE_CNT_EN)
//
// Ports
//   sck        in   SPI clock; all state changes on posedge
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle pulse that begins read-out (accepted in IDLE only)
//   stop       in   end of transaction (CS# deasserted), synchronous
//   io_mode    in   00=x1, 01=x2, 10=x4, 11=x1; latched at start
//   dummy_cnt  in   number of dummy clocks before first data; latched at start
//   data_in    in   byte from the read stage, consumed at the edge where rd_req=1
//   rd_req     out  combinational read strobe to the read stage
//   io_out     out  pad data (x1 on [1], x2 on [1:0], x4 on [3:0])
//   io_oe      out  pad output enables (x1=0010, x2=0011, x4=1111, else 0000)
//   byte_done  out  registered 1-cycle pulse after the last slot of each byte
//   byte_cnt   out  saturating count of completed bytes (DOUT_BYTE_CNT_EN)
// ---------------------------------------------------------------------------
module spi_dout_shifter #(
  parameter int unsigned DUMMY_W = 5
`ifdef DOUT_BYTE_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic               sck,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         io_mode,
  input  logic [DUMMY_W-1:0] dummy_cnt,
  input  logic [7:0]         data_in,
  output logic               rd_req,
  output logic [3:0]         io_out,
  output logic [3:0]         io_oe,
  output logic               byte_done
`ifdef DOUT_BYTE_CNT_EN
  ,
  output logic [CNT_W-1:0]   byte_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DUMMY = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_mode;
  logic [7:0]         r_shreg;
  logic [2:0]         r_slot;
  logic [DUMMY_W-1:0] r_dcnt;
  logic               r_byte_done;

  logic               w_start_ok;
  logic [2:0]         w_last_slot;
  logic               w_last;
  logic [7:0]         w_shifted;
  logic               w_rd_req;
  logic [3:0]         w_io_out;
  logic [3:0]         w_io_oe;

  // Start counts only in IDLE, and stop in the same cycle cancels it.
  assign w_start_ok = (r_state == ST_IDLE) && start && !stop;

  // Per-mode slot count and shift step. The latched mode is never 11.
  always_comb begin
    w_last_slot = 3'd7;
    w_shifted   = {r_shreg[6:0], 1'b0};
    case (r_mode)
      2'b01: begin
        w_last_slot = 3'd3;
        w_shifted   = {r_shreg[5:0], 2'b00};
      end
      2'b10: begin
        w_last_slot = 3'd1;
        w_shifted   = {r_shreg[3:0], 4'b0000};
      end
      default: ;
    endcase
  end

  assign w_last = (r_slot == w_last_slot);

  // State register
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_next = (dummy_cnt == '0) ? ST_SHIFT : ST_DUMMY;
      end
      ST_DUMMY: begin
        if (stop)                            w_next = ST_IDLE;
        else if (r_dcnt == DUMMY_W'(1))      w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (stop) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output logic. rd_req is held low whenever stop is high: stop wins.
  always_comb begin
    w_rd_req = 1'b0;
    w_io_out = '0;
    w_io_oe  = '0;
    case (r_state)
      ST_IDLE:  w_rd_req = w_start_ok && (dummy_cnt == '0);
      ST_DUMMY: w_rd_req = !stop && (r_dcnt == DUMMY_W'(1));
      ST_SHIFT: begin
        w_rd_req = !stop && w_last;
        case (r_mode)
          2'b01: begin
            w_io_out = {2'b00, r_shreg[7:6]};
            w_io_oe  = 4'b0011;
          end
          2'b10: begin
            w_io_out = r_shreg[7:4];
            w_io_oe  = 4'b1111;
          end
          default: begin
            w_io_out = {2'b00, r_shreg[7], 1'b0};
            w_io_oe  = 4'b0010;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign rd_req = w_rd_req;
  assign io_out = w_io_out;
  assign io_oe  = w_io_oe;

  // Datapath: shift register, slot counter, dummy counter, mode latch.
  // Every load (from IDLE, DUMMY or the last slot) goes through rd_req, so
  // a single load path covers all three cases.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= '0;
      r_shreg     <= '0;
      r_slot      <= '0;
      r_dcnt      <= '0;
      r_byte_done <= 1'b0;
    end else begin
      r_byte_done <= (r_state == ST_SHIFT) && w_last;

      if (w_start_ok) begin
        r_mode <= (io_mode == 2'b11) ? 2'b00 : io_mode;
        r_dcnt <= dummy_cnt;
      end else if (r_state == ST_DUMMY) begin
        r_dcnt <= stop ? '0 : r_dcnt - DUMMY_W'(1);
      end

      if (w_rd_req) begin
        r_shreg <= data_in;
        r_slot  <= '0;
      end else if (r_state == ST_SHIFT) begin
        if (stop) begin
          r_shreg <= '0;
          r_slot  <= '0;
        end else begin
          r_shreg <= w_shifted;
          r_slot  <= r_slot + 3'd1;
        end
      end
    end
  end

  assign byte_done = r_byte_done;

`ifdef DOUT_BYTE_CNT_EN
  logic [CNT_W-1:0] r_byte_cnt;

  // Counts up on the same edge that raises byte_done, and stops at all ones.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
    end else if (w_start_ok) begin
      r_byte_cnt <= '0;
    end else if ((r_state == ST_SHIFT) && w_last && (r_byte_cnt != '1)) begin
      r_byte_cnt <= r_byte_cnt + CNT_W'(1);
    end
  end

  assign byte_cnt = r_byte_cnt;
`endif

endmodule

// File: tb/tb_spi_dout_shifter.sv
// Testbench for spi_dout_shifter. Checks reset values, a table of per-cycle
// vectors, asynchronous reset in the middle of a byte, and (when
// DOUT_BYTE_CNT_EN is defined) the saturating byte counter.
module tb_spi_dout_shifter;

  logic       sck = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] io_mode;
  logic [4:0] dummy_cnt;
  logic [7:0] data_in;
  logic       rd_req;
  logic [3:0] io_out;
  logic [3:0] io_oe;
  logic       byte_done;
`ifdef DOUT_BYTE_CNT_EN
  logic [1:0] byte_cnt;
`endif

  always #5 sck = ~sck;

  spi_dout_shifter #(
    .DUMMY_W(5)
`ifdef DOUT_BYTE_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .sck(sck),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .io_mode(io_mode),
    .dummy_cnt(dummy_cnt),
    .data_in(data_in),
    .rd_req(rd_req),
    .io_out(io_out),
    .io_oe(io_oe),
    .byte_done(byte_done)
`ifdef DOUT_BYTE_CNT_EN
    , .byte_cnt(byte_cnt)
`endif
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [4:0] dcnt;
    logic [7:0] din;
    logic       rd;
    logic [3:0] out;
    logic [3:0] oe;
    logic       bd;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic s, input logic p, input logic [1:0] m,
                            input logic [4:0] d, input logic [7:0] di,
                            input logic r, input logic [3:0] o,
                            input logic [3:0] e, input logic b);
    vec_t t;
    t.start = s; t.stop = p; t.mode = m; t.dcnt = d; t.din = di;
    t.rd = r; t.out = o; t.oe = e; t.bd = b;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs 1 time unit after the clock edge and check 2 units later.
  // Outputs then show the state after the edge together with the current inputs.
  task automatic settle_and_tick();
    @(posedge sck);
    #1;
  endtask

  initial begin
    // Each vector is one cycle: {start, stop, mode, dummy, din} -> {rd, out, oe, bd}.
    // x1, D=0, A5 = 1,0,1,0,0,1,0,1, stop during slot 7.
    v(1,0,2'd0,5'd0,8'hA5, 1,4'h0,4'h0,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h2,4'h2,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h2,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h2,4'h2,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h2,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h2,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h2,4'h2,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h2,0);
    v(0,1,2'd0,5'd0,8'h00, 0,4'h2,4'h2,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h0,1);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h0,0);
    // x4, D=8, stream 12,34,56. Mode and dummy inputs change after start and are ignored.
    v(1,0,2'd2,5'd8,8'h00, 0,4'h0,4'h0,0);
    for (int i = 0; i < 7; i++) v(0,0,2'd0,5'd3,8'h00, 0,4'h0,4'h0,0);
    v(0,0,2'd0,5'd3,8'h12, 1,4'h0,4'h0,0);
    v(0,0,2'd0,5'd3,8'h00, 0,4'h1,4'hF,0);
    v(0,0,2'd0,5'd3,8'h34, 1,4'h2,4'hF,0);
    v(0,0,2'd0,5'd3,8'h00, 0,4'h3,4'hF,1);
    v(0,0,2'd0,5'd3,8'h56, 1,4'h4,4'hF,0);
    v(0,0,2'd0,5'd3,8'h00, 0,4'h5,4'hF,1);
    v(0,1,2'd0,5'd3,8'h00, 0,4'h6,4'hF,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h0,1);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h0,0);
    // x2, D=0, C3, stop during slot 1: byte abandoned, no byte_done.
    v(1,0,2'd1,5'd0,8'hC3, 1,4'h0,4'h0,0);
    v(0,0,2'd1,5'd0,8'h00, 0,4'h3,4'h3,0);
    v(0,1,2'd1,5'd0,8'h00, 0,4'h0,4'h3,0);
    v(0,0,2'd1,5'd0,8'h00, 0,4'h0,4'h0,0);
    v(0,0,2'd1,5'd0,8'h00, 0,4'h0,4'h0,0);
    // start & stop together in IDLE, then a start pulse during SHIFT.
    v(1,1,2'd0,5'd0,8'hFF, 0,4'h0,4'h0,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h0,0);
    v(1,0,2'd0,5'd0,8'h80, 1,4'h0,4'h0,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h2,4'h2,0);
    v(1,0,2'd2,5'd0,8'hFF, 0,4'h0,4'h2,0);
    for (int i = 0; i < 5; i++) v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h2,0);
    v(0,1,2'd0,5'd0,8'h00, 0,4'h0,4'h2,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h0,1);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h0,0);
    // Reserved mode 11 behaves as x1, D=1 is the shortest dummy run.
    v(1,0,2'd3,5'd1,8'h00, 0,4'h0,4'h0,0);
    v(0,0,2'd0,5'd0,8'h40, 1,4'h0,4'h0,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h2,0);
    v(0,1,2'd0,5'd0,8'h00, 0,4'h2,4'h2,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h0,0);
    // stop in DUMMY exactly when dcnt==1: no rd_req, back to IDLE.
    v(1,0,2'd0,5'd2,8'h00, 0,4'h0,4'h0,0);
    v(0,0,2'd0,5'd0,8'h00, 0,4'h0,4'h0,0);
    v(0,1,2'd0,5'd0,8'hAA, 0,4'h0,4'h0,0);
    for (int i = 0; i < 3; i++) v(0,0,2'd0,5'd0,8'hAA, 0,4'h0,4'h0,0);

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    io_mode = 2'd0; dummy_cnt = 5'd0; data_in = 8'h00;
    #12;
    check("reset_outputs", {6'd0, rd_req, io_out, io_oe, byte_done}, 16'h0000);
`ifdef DOUT_BYTE_CNT_EN
    check("reset_byte_cnt", {14'd0, byte_cnt}, 16'h0000);
`endif
    #1 rst_n = 1'b1;
    settle_and_tick();

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; stop = vecs[i].stop; io_mode = vecs[i].mode;
      dummy_cnt = vecs[i].dcnt; data_in = vecs[i].din;
      #2;
      check($sformatf("vec%0d", i), {6'd0, rd_req, io_out, io_oe, byte_done},
            {6'd0, vecs[i].rd, vecs[i].out, vecs[i].oe, vecs[i].bd});
      settle_and_tick();
    end
    start = 1'b0; stop = 1'b0; dummy_cnt = 5'd0; data_in = 8'h00;

    // Async reset in the middle of an x4 byte: outputs clear before any clock edge.
    start = 1'b1; io_mode = 2'd2; data_in = 8'hAB;
    #2 settle_and_tick();
    start = 1'b0; data_in = 8'h00;
    #2;
    check("x4_before_reset", {8'd0, io_out, io_oe}, 16'h00AF);
    rst_n = 1'b0;
    #1;
    check("async_reset", {6'd0, rd_req, io_out, io_oe, byte_done}, 16'h0000);
    settle_and_tick();
    rst_n = 1'b1;
    settle_and_tick();
    start = 1'b1; io_mode = 2'd0; data_in = 8'h80;
    #2;
    check("post_reset_rd", {15'd0, rd_req}, 16'h0001);
    settle_and_tick();
    start = 1'b0; stop = 1'b1; data_in = 8'h00;
    #2;
    check("post_reset_x1", {7'd0, io_out, io_oe, byte_done}, 16'h0044);
    settle_and_tick();
    stop = 1'b0;
    #2;
    check("post_reset_idle", {6'd0, rd_req, io_out, io_oe, byte_done}, 16'h0000);
    settle_and_tick();

`ifdef DOUT_BYTE_CNT_EN
    // Five x1 bytes back to back with CNT_W=2: the count saturates at 3.
    start = 1'b1; io_mode = 2'd0; dummy_cnt = 5'd0; data_in = 8'h5A;
    #2 settle_and_tick();
    start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      for (int s = 0; s < 8; s++) begin
        stop = (b == 4 && s == 7);
        #2 settle_and_tick();
      end
      check($sformatf("byte_cnt_%0d", b), {14'd0, byte_cnt},
            16'((b + 1 > 3) ? 3 : b + 1));
    end
    stop = 1'b0;
    settle_and_tick();
    start = 1'b1;
    #2 settle_and_tick();
    start = 1'b0;
    #2;
    check("byte_cnt_clear", {14'd0, byte_cnt}, 16'h0000);
    settle_and_tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
